adler32_check: RTL and testbench



---
 rtl/adler32_check_if.sv | 23 ++
 rtl/adler32_check.sv | 114 +++++++++++
 tb/tb_adler32_check.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/adler32_check_if.sv
// Byte-stream input and verdict output bundle for the Adler-32 trailer checker.
interface adler32_check_if;
  logic        data_valid;
  logic [7:0]  data;
  logic        last_data;
  logic        done;
  logic        pass;
  logic        short_err;
  logic [31:0] checksum;
  logic [31:0] rx_checksum;

  // Stream source / verdict consumer side
  modport master (
    output data_valid, data, last_data,
    input  done, pass, short_err, checksum, rx_checksum
  );

  // Checker side
  modport slave (
    input  data_valid, data, last_data,
    output done, pass, short_err, checksum, rx_checksum
  );
endinterface

// File: rtl/adler32_check.sv
// Receive-side Adler-32 checker: the last 4 bytes of each packet are the
// trailer, everything before them is payload. A 4-byte delay line holds back
// the newest bytes so that only bytes known to be payload reach the running
// sum; the delay line then holds the trailer when last_data arrives.
module adler32_check #(
  parameter logic [15:0] MOD        = 16'd65521,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic           clock,
  input  logic           rst,
  adler32_check_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, CHECK = 1'b1} state_t;

  state_t          state_q;
  logic [15:0]     a_q, b_q;
  logic [2:0]      count_q;
  logic [3:0][7:0] dl_q;        // dl_q[0] newest byte, dl_q[3] oldest
  logic            done_q, pass_q, short_q;
  logic [31:0]     sum_q, rx_q;

  logic [3:0][7:0] dl_d;
  logic [2:0]      count_d;
  logic [16:0]     a_sum, b_sum;
  logic [15:0]     a_d, b_d;
  logic [31:0]     rx_full_d, rx_d;

  // Delay line after shifting in the current byte; count saturates at 4
  assign dl_d    = {dl_q[2:0], bus.data};
  assign count_d = (count_q >= 3'd4) ? 3'd4 : count_q + 3'd1;

  // Fold the evicted oldest byte into A and B; one conditional subtract each
  always_comb begin
    a_sum = {1'b0, a_q} + {9'd0, dl_q[3]};
    a_d   = (a_sum >= {1'b0, MOD}) ? 16'(a_sum - {1'b0, MOD}) : a_sum[15:0];
    b_sum = {1'b0, b_q} + {1'b0, a_d};
    b_d   = (b_sum >= {1'b0, MOD}) ? 16'(b_sum - {1'b0, MOD}) : b_sum[15:0];
  end

  // Full trailer word: first received byte lands in the MSB (big endian)
  // or in the LSB (little endian)
  for (genvar gi = 0; gi < 4; gi++) begin : g_rx
    if (BIG_ENDIAN) begin : g_be
      assign rx_full_d[8*gi +: 8] = dl_d[gi];
    end else begin : g_le
      assign rx_full_d[8*gi +: 8] = dl_d[3-gi];
    end
  end

  // Short packets report whatever arrived, left-justified and zero-filled
  always_comb begin
    rx_d = rx_full_d;
    case (count_d)
      3'd1:    rx_d = {dl_d[0], 24'h0};
      3'd2:    rx_d = {dl_d[1], dl_d[0], 16'h0};
      3'd3:    rx_d = {dl_d[2], dl_d[1], dl_d[0], 8'h0};
      default: rx_d = rx_full_d;
    endcase
  end

  // Accumulate in ACCUM, deliver the verdict and rearm in CHECK
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ACCUM;
      a_q     <= 16'd1;
      b_q     <= 16'd0;
      count_q <= 3'd0;
      dl_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      short_q <= 1'b0;
      sum_q   <= 32'd0;
      rx_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (bus.data_valid) begin
            dl_q    <= dl_d;
            count_q <= count_d;
            if (count_q >= 3'd4) begin
              a_q <= a_d;
              b_q <= b_d;
            end
            if (bus.last_data) begin
              rx_q    <= rx_d;
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          sum_q   <= {b_q, a_q};
          pass_q  <= (count_q >= 3'd4) && ({b_q, a_q} == rx_q);
          short_q <= (count_q < 3'd4);
          done_q  <= 1'b1;
          a_q     <= 16'd1;
          b_q     <= 16'd0;
          count_q <= 3'd0;
          dl_q    <= '0;
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.short_err   = short_q;
  assign bus.checksum    = sum_q;
  assign bus.rx_checksum = rx_q;

endmodule

// File: tb/tb_adler32_check.sv
// Bench for adler32_check: a vector table of packets plus hand-written
// sequences (gaps, reset mid-packet, junk during CHECK, long packet, little
// endian). Expected verdicts are queued when the last byte is driven and
// compared when done pulses.
module tb_adler32_check;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adler32_check_if bus0 ();
  adler32_check_if bus1 ();

  adler32_check #(.MOD(16'd65521), .BIG_ENDIAN(1'b1)) dut0 (
    .clock(clk), .rst(rst), .bus(bus0.slave)
  );
  adler32_check #(.MOD(16'd65521), .BIG_ENDIAN(1'b0)) dut1 (
    .clock(clk), .rst(rst), .bus(bus1.slave)
  );

  typedef struct {
    logic        pass;
    logic        short_err;
    logic [31:0] sum;
    logic [31:0] rx;
    int          cyc;
  } exp_t;

  typedef struct {
    int          len;
    logic [95:0] data;      // bytes left-justified, first byte in [95:88]
    logic        pass;
    logic        short_err;
    logic [31:0] sum;
    logic [31:0] rx;
  } vec_t;

  exp_t       q0[$];
  exp_t       q1[$];
  vec_t       vecs[8];
  logic [7:0] pkt[0:1099];
  int         pkt_len;
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_done(input bit which);
    exp_t        e;
    logic        p, s;
    logic [31:0] c, r;
    p = which ? bus1.pass        : bus0.pass;
    s = which ? bus1.short_err   : bus0.short_err;
    c = which ? bus1.checksum    : bus0.checksum;
    r = which ? bus1.rx_checksum : bus0.rx_checksum;
    if ((which ? q1.size() : q0.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_done dut%0d: got done=1 expected done=0 at cycle %0d", which, cyc);
    end else begin
      e = which ? q1.pop_front() : q0.pop_front();
      $display("[TB] dut%0d done cyc=%0d pass=%0d short=%0d sum=%08h rx=%08h", which, cyc, p, s, c, r);
      chk("pass",        {31'd0, p}, {31'd0, e.pass});
      chk("short_err",   {31'd0, s}, {31'd0, e.short_err});
      chk("checksum",    c, e.sum);
      chk("rx_checksum", r, e.rx);
      chk("latency",     cyc, e.cyc);
    end
  endtask

  // Verdict monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && bus0.done) check_done(1'b0);
    if (!rst && bus1.done) check_done(1'b1);
  end

  task automatic set_in(input bit which, input logic v, input logic [7:0] d, input logic l);
    if (which) begin
      bus1.data_valid = v; bus1.data = d; bus1.last_data = l;
    end else begin
      bus0.data_valid = v; bus0.data = d; bus0.last_data = l;
    end
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive pkt[0..pkt_len-1] with optional random gaps; queue the verdict
  task automatic send_pkt(input bit which, input int max_gap, input logic ep,
                          input logic es, input logic [31:0] esum, input logic [31:0] erx);
    exp_t e;
    for (int i = 0; i < pkt_len; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        set_in(which, 1'b0, 8'($urandom), 1'($urandom));
        @(posedge clk); #1;
      end
      set_in(which, 1'b1, pkt[i], (i == pkt_len - 1));
      @(posedge clk); #1;
    end
    e.pass = ep; e.short_err = es; e.sum = esum; e.rx = erx; e.cyc = cyc + 1;
    if (which) q1.push_back(e); else q0.push_back(e);
    set_in(which, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic load_vec(input vec_t v);
    pkt_len = v.len;
    for (int k = 0; k < v.len; k++) pkt[k] = v.data[95 - 8*k -: 8];
  endtask

  task automatic load_hello(input logic [31:0] trailer);
    logic [39:0] h;
    h = 40'h48656c6c6f;
    for (int k = 0; k < 5; k++) pkt[k] = h[39 - 8*k -: 8];
    for (int k = 0; k < 4; k++) pkt[5 + k] = trailer[31 - 8*k -: 8];
    pkt_len = 9;
  endtask

  initial begin
    vecs[0] = '{9, {72'h48656c6c6f058c01f5, 24'h0}, 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5};
    vecs[1] = '{9, {72'h48656c6c6f058c01f4, 24'h0}, 1'b0, 1'b0, 32'h058c01f5, 32'h058c01f4};
    vecs[2] = '{4, {32'h00000001, 64'h0},           1'b1, 1'b0, 32'h00000001, 32'h00000001};
    vecs[3] = '{2, {16'h1234, 80'h0},               1'b0, 1'b1, 32'h00000001, 32'h12340000};
    vecs[4] = '{1, {8'hab, 88'h0},                  1'b0, 1'b1, 32'h00000001, 32'hab000000};
    vecs[5] = '{3, {24'h010203, 72'h0},             1'b0, 1'b1, 32'h00000001, 32'h01020300};
    vecs[6] = '{5, {40'h0100020002, 56'h0},         1'b1, 1'b0, 32'h00020002, 32'h00020002};
    vecs[7] = '{4, {32'h00000002, 64'h0},           1'b0, 1'b0, 32'h00000001, 32'h00000002};

    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done0",  {31'd0, bus0.done},      32'd0);
    chk("rst_pass0",  {31'd0, bus0.pass},      32'd0);
    chk("rst_short0", {31'd0, bus0.short_err}, 32'd0);
    chk("rst_sum0",   bus0.checksum,           32'd0);
    chk("rst_rx0",    bus0.rx_checksum,        32'd0);
    chk("rst_done1",  {31'd0, bus1.done},      32'd0);
    chk("rst_sum1",   bus1.checksum,           32'd0);
    rst = 1'b0;
    idle(2);

    // Table of packets, back-to-back bytes
    for (int v = 0; v < 8; v++) begin
      load_vec(vecs[v]);
      send_pkt(1'b0, 0, vecs[v].pass, vecs[v].short_err, vecs[v].sum, vecs[v].rx);
      idle(3);
    end

    // Same verdicts with random gaps and random data/last while invalid
    for (int r = 0; r < 4; r++) begin
      load_vec(vecs[0]);
      send_pkt(1'b0, 9, 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5);
      idle(3);
      load_vec(vecs[3]);
      send_pkt(1'b0, 9, 1'b0, 1'b1, 32'h00000001, 32'h12340000);
      idle(3);
    end

    // Byte presented during CHECK is dropped; following packet unaffected
    load_vec(vecs[0]);
    send_pkt(1'b0, 0, 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5);
    set_in(1'b0, 1'b1, 8'haa, 1'b1);
    @(posedge clk); #1;
    idle(3);
    load_vec(vecs[0]);
    send_pkt(1'b0, 0, 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5);
    idle(3);

    // Long packet exercising modular wrap of A and B
    for (int k = 0; k < 1024; k++) pkt[k] = 8'hff;
    pkt[1024] = 8'h79; pkt[1025] = 8'ha6; pkt[1026] = 8'hfc; pkt[1027] = 8'h2e;
    pkt_len = 1028;
    send_pkt(1'b0, 0, 1'b1, 1'b0, 32'h79a6fc2e, 32'h79a6fc2e);
    idle(3);

    // Reset after 3 bytes: no verdict for the discarded packet
    load_hello(32'h058c01f5);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, pkt[k], 1'b0);
      @(posedge clk); #1;
    end
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_done", {31'd0, bus0.done}, 32'd0);
    chk("midrst_pass", {31'd0, bus0.pass}, 32'd0);
    chk("midrst_sum",  bus0.checksum,      32'd0);
    rst = 1'b0;
    idle(2);
    send_pkt(1'b0, 0, 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5);
    idle(3);

    // Little-endian trailer
    load_hello(32'hf5018c05);
    send_pkt(1'b1, 0, 1'b1, 1'b0, 32'h058c01f5, 32'h058c01f5);
    idle(3);
    load_hello(32'hf4018c05);
    send_pkt(1'b1, 3, 1'b0, 1'b0, 32'h058c01f5, 32'h058c01f4);
    idle(3);
    load_vec(vecs[3]);
    send_pkt(1'b1, 0, 1'b0, 1'b1, 32'h00000001, 32'h12340000);
    idle(3);

    // Drain with a bound; any leftover expectation is a missing done
    for (int w = 0; w < 50 && (q0.size() + q1.size()) > 0; w++) begin
      @(posedge clk); #1;
    end
    tests++;
    if ((q0.size() + q1.size()) != 0) begin
      fails++;
      $display("FAIL missing_done: got %0d pending verdicts expected 0", q0.size() + q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
